decode_stage_pipe: RTL
======================

Name: decode_stage_pipe

Overview:
- Parametrised successor to the 16-bit decode stage.
- Decodes one instruction word per accepted beat and reads two source registers from an internal register file with write-back bypass.
- Assembles two-word LDM (opcode word followed by an immediate word) with a small state machine.
- Registers the result into an ID/EX pipeline register, with valid/ready handshakes on both sides plus a flush.
- Sits between fetch and execute.

Parameters:
- DATA_W, 16, instruction, immediate and register width.
- REG_COUNT, 8, number of architectural registers; must be a power of two and at least 2.
- ADDR_W, $clog2(REG_COUNT), register address width.
- OPC_W, 5, opcode width. Must satisfy OPC_W + 3*ADDR_W <= DATA_W.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  drops any pending instruction.
- in_valid  in  1  fetch word valid.
- in_ready  out  1  stage accepts the word this cycle.
- in_instr  in  DATA_W  instruction or immediate word.
- wb_en  in  1  write-back enable.
- wb_addr  in  ADDR_W  write-back register.
- wb_data  in  DATA_W  write-back value.
- out_valid  out  1  ID/EX register holds a decoded instruction.
- out_ready  in  1  execute consumes it.
- out_reg_write, out_mem_write, out_mem_read, out_alu_src, out_mem_to_reg  out  1 each  control bits.
- out_alu_ctrl  out  3  ALU operation.
- out_rdata1, out_rdata2  out  DATA_W  source operands.
- out_imm  out  DATA_W  immediate (0 if none).
- out_rdst  out  ADDR_W  destination register.
- out_illegal  out  1  undefined opcode decoded.

Behaviour:
- Field layout:
  - opcode = in_instr[DATA_W-1 -: OPC_W]
  - rdst = next ADDR_W bits down
  - rsrc1 = the ADDR_W bits below rdst
  - rsrc2 = the ADDR_W bits below rsrc1
  - remaining low bits ignored.
- Opcodes and decode:
  - LDM 00001: reg_write=1, alu_src=1, alu_ctrl=010.
  - STD 00010: mem_write=1, alu_ctrl=011.
  - ADD 00011: reg_write=1, alu_ctrl=000.
  - NOT 00100: reg_write=1, alu_ctrl=001.
  - NOP 00101: alu_ctrl=100.
  - Any other opcode: NOP controls with out_illegal=1.
  - Unlisted control bits are 0.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - A word is accepted when in_valid && in_ready.
  - The output holds stable while out_valid && !out_ready.
  - Latency is 1 cycle from acceptance of the final word to out_valid.
- FSM states:
  - S_DEC: accepting LDM latches rdst, moves to S_IMM, and does not assert out_valid. Any other accepted opcode loads the ID/EX register and sets out_valid.
  - S_IMM: the next accepted word becomes out_imm, the LDM is issued with out_valid=1, and the FSM returns to S_DEC.
  - A word accepted while in S_IMM is never decoded as an opcode.
- out_valid clears on out_ready when no new word is accepted in the same cycle.
- Register file:
  - REG_COUNT x DATA_W.
  - Write occurs at the clock edge when wb_en is high; wb_en is independent of the handshake.
  - Reads are combinational and captured into out_rdata* at acceptance.
  - Bypass: if wb_en and wb_addr equals the source address in the same cycle, wb_data is captured.
  - For LDM, out_rdata1 and out_rdata2 are 0.
- Flush (has priority over acceptance):
  - Next cycle: out_valid=0 and FSM=S_DEC.
  - in_ready is still computed normally, but words presented are discarded.
  - The register file is untouched.
- Reset:
  - All outputs 0, in_ready=1 after reset.
  - FSM=S_DEC, all registers 0.
  - Mid-LDM reset discards the partial instruction.
- Reset > flush > accept.
- A write-back concurrent with reset is ignored.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams (OPC_LDM..OPC_NOP)
  - ALU control localparams (ALU_ADD=000, ALU_NOT=001, ALU_PASSB=010, ALU_STD=011, ALU_NOP=100)
  - FSM state enum {S_DEC, S_IMM}
  - a ctrl_t struct bundling the six control fields.
- One sub-module: regfile_bypass, holding the parametrised storage, two combinational read ports and the same-cycle bypass mux.
- The FSM, decoder and ID/EX register stay in the top module.

Test Plan:
- Reset, then write R3=0x1234 via wb; issue ADD rdst=1, rsrc1=3, rsrc2=3 -> next cycle out_valid=1, alu_ctrl=000, reg_write=1, rdata1=rdata2=0x1234.
- LDM rdst=5 word, then immediate 0xBEEF -> no out_valid after first word; after second word out_valid=1, out_imm=0xBEEF, alu_src=1, out_rdst=5.
- out_ready held 0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen; release -> next word accepted the same cycle.
- ADD reading R2 while wb_en=1, wb_addr=2, wb_data=0x00AA in the same cycle -> out_rdata1=0x00AA (bypass).
- Flush asserted in S_IMM, then STD word -> no LDM issued; STD decoded with mem_write=1, alu_ctrl=011.
- Opcode 11111 -> out_illegal=1 with NOP controls; reset asserted mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/decode_stage_pipe_pkg.sv
// rtl/decode_stage_pipe_pkg.sv - shared opcodes, ALU codes, FSM state and control bundle
// Decode helpers are plain functions so the top stays a thin register/FSM shell.
package decode_pkg;

   localparam logic [4:0] OPC_LDM = 5'b00001;
   localparam logic [4:0] OPC_STD = 5'b00010;
   localparam logic [4:0] OPC_ADD = 5'b00011;
   localparam logic [4:0] OPC_NOT = 5'b00100;
   localparam logic [4:0] OPC_NOP = 5'b00101;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_NOT   = 3'b001;
   localparam logic [2:0] ALU_PASSB = 3'b010;
   localparam logic [2:0] ALU_STD   = 3'b011;
   localparam logic [2:0] ALU_NOP   = 3'b100;

   typedef enum logic {S_DEC, S_IMM} state_t;

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       mem_read;
      logic       alu_src;
      logic       mem_to_reg;
      logic [2:0] alu_ctrl;
   } ctrl_t;

   // Undefined opcodes fall through to NOP controls; legality is reported separately.
   function automatic ctrl_t decode_ctrl(input logic [4:0] opc);
      ctrl_t c;
      c          = '0;
      c.alu_ctrl = ALU_NOP;
      case (opc)
         OPC_LDM: begin
            c.reg_write = 1'b1;
            c.alu_src   = 1'b1;
            c.alu_ctrl  = ALU_PASSB;
         end
         OPC_STD: begin
            c.mem_write = 1'b1;
            c.alu_ctrl  = ALU_STD;
         end
         OPC_ADD: begin
            c.reg_write = 1'b1;
            c.alu_ctrl  = ALU_ADD;
         end
         OPC_NOT: begin
            c.reg_write = 1'b1;
            c.alu_ctrl  = ALU_NOT;
         end
         default: ;
      endcase
      return c;
   endfunction

   function automatic logic opc_illegal(input logic [4:0] opc);
      return !(opc inside {OPC_LDM, OPC_STD, OPC_ADD, OPC_NOT, OPC_NOP});
   endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// rtl/decode_stage_pipe_if.sv - fetch, write-back and ID/EX signal bundle
// master is the fetch/execute/write-back environment, slave is the decode stage.
interface decode_stage_pipe_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_instr;

   logic              wb_en;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;

   logic              out_valid;
   logic              out_ready;
   logic              out_reg_write;
   logic              out_mem_write;
   logic              out_mem_read;
   logic              out_alu_src;
   logic              out_mem_to_reg;
   logic [2:0]        out_alu_ctrl;
   logic [DATA_W-1:0] out_rdata1;
   logic [DATA_W-1:0] out_rdata2;
   logic [DATA_W-1:0] out_imm;
   logic [ADDR_W-1:0] out_rdst;
   logic              out_illegal;

   modport master (
      output in_valid, in_instr, wb_en, wb_addr, wb_data, out_ready,
      input  in_ready, out_valid, out_reg_write, out_mem_write, out_mem_read,
             out_alu_src, out_mem_to_reg, out_alu_ctrl, out_rdata1, out_rdata2,
             out_imm, out_rdst, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, wb_en, wb_addr, wb_data, out_ready,
      output in_ready, out_valid, out_reg_write, out_mem_write, out_mem_read,
             out_alu_src, out_mem_to_reg, out_alu_ctrl, out_rdata1, out_rdata2,
             out_imm, out_rdst, out_illegal
   );

endinterface

// File: rtl/decode_stage_pipe_regfile_bypass.sv
// rtl/decode_stage_pipe_regfile_bypass.sv - register file with two async reads and same-cycle write bypass
// Reset clears the array and suppresses any concurrent write-back.
module regfile_bypass #(
   parameter int DATA_W    = 16,
   parameter int REG_COUNT = 8,
   parameter int ADDR_W    = $clog2(REG_COUNT)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_wb_en,
   input  logic [ADDR_W-1:0] i_wb_addr,
   input  logic [DATA_W-1:0] i_wb_data,
   input  logic [ADDR_W-1:0] i_raddr1,
   input  logic [ADDR_W-1:0] i_raddr2,
   output logic [DATA_W-1:0] o_rdata1,
   output logic [DATA_W-1:0] o_rdata2
);

   logic [DATA_W-1:0] r_mem [REG_COUNT];
   logic              w_hit1;
   logic              w_hit2;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_wb_en) begin
         r_mem[i_wb_addr] <= i_wb_data;
      end
   end

   // A reader in the same cycle as the write sees the value being written.
   assign w_hit1   = i_wb_en && (i_wb_addr == i_raddr1);
   assign w_hit2   = i_wb_en && (i_wb_addr == i_raddr2);
   assign o_rdata1 = w_hit1 ? i_wb_data : r_mem[i_raddr1];
   assign o_rdata2 = w_hit2 ? i_wb_data : r_mem[i_raddr2];

endmodule

// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - instruction decode stage with LDM assembly and ID/EX register
// Priority inside the state update is reset, then flush, then word acceptance.
module decode_stage_pipe
   import decode_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int REG_COUNT = 8,
   parameter int ADDR_W    = $clog2(REG_COUNT),
   parameter int OPC_W     = 5
) (
   input logic                clk,
   input logic                reset,
   input logic                flush,
   decode_stage_pipe_if.slave bus
);

   logic              w_in_ready;
   logic              w_accept;
   logic [OPC_W-1:0]  w_opcode;
   logic [ADDR_W-1:0] w_rdst;
   logic [ADDR_W-1:0] w_rsrc1;
   logic [ADDR_W-1:0] w_rsrc2;
   logic [DATA_W-1:0] w_rdata1;
   logic [DATA_W-1:0] w_rdata2;
   ctrl_t             w_ctrl;
   logic              w_illegal;

   state_t            r_state;
   logic [ADDR_W-1:0] r_ldm_rdst;
   logic              r_out_valid;
   ctrl_t             r_ctrl;
   logic [DATA_W-1:0] r_rdata1;
   logic [DATA_W-1:0] r_rdata2;
   logic [DATA_W-1:0] r_imm;
   logic [ADDR_W-1:0] r_rdst;
   logic              r_illegal;

   assign w_opcode = bus.in_instr[DATA_W-1 -: OPC_W];
   assign w_rdst   = bus.in_instr[DATA_W-OPC_W-1 -: ADDR_W];
   assign w_rsrc1  = bus.in_instr[DATA_W-OPC_W-ADDR_W-1 -: ADDR_W];
   assign w_rsrc2  = bus.in_instr[DATA_W-OPC_W-2*ADDR_W-1 -: ADDR_W];

   assign w_ctrl    = decode_ctrl(w_opcode);
   assign w_illegal = opc_illegal(w_opcode);

   assign w_in_ready = !r_out_valid || bus.out_ready;
   assign w_accept   = bus.in_valid && w_in_ready;

   regfile_bypass #(
      .DATA_W   (DATA_W),
      .REG_COUNT(REG_COUNT),
      .ADDR_W   (ADDR_W)
   ) u_regfile (
      .i_clk    (clk),
      .i_reset  (reset),
      .i_wb_en  (bus.wb_en),
      .i_wb_addr(bus.wb_addr),
      .i_wb_data(bus.wb_data),
      .i_raddr1 (w_rsrc1),
      .i_raddr2 (w_rsrc2),
      .o_rdata1 (w_rdata1),
      .o_rdata2 (w_rdata2)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_DEC;
         r_ldm_rdst  <= '0;
         r_out_valid <= 1'b0;
         r_ctrl      <= '0;
         r_rdata1    <= '0;
         r_rdata2    <= '0;
         r_imm       <= '0;
         r_rdst      <= '0;
         r_illegal   <= 1'b0;
      end else if (flush) begin
         r_state     <= S_DEC;
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         case (r_state)
            S_DEC: begin
               if (w_opcode == OPC_LDM) begin
                  // Hold the destination until the immediate word arrives.
                  r_ldm_rdst  <= w_rdst;
                  r_state     <= S_IMM;
                  r_out_valid <= 1'b0;
               end else begin
                  r_out_valid <= 1'b1;
                  r_ctrl      <= w_ctrl;
                  r_rdata1    <= w_rdata1;
                  r_rdata2    <= w_rdata2;
                  r_imm       <= '0;
                  r_rdst      <= w_rdst;
                  r_illegal   <= w_illegal;
               end
            end
            S_IMM: begin
               r_out_valid <= 1'b1;
               r_ctrl      <= decode_ctrl(OPC_LDM);
               r_rdata1    <= '0;
               r_rdata2    <= '0;
               r_imm       <= bus.in_instr;
               r_rdst      <= r_ldm_rdst;
               r_illegal   <= 1'b0;
               r_state     <= S_DEC;
            end
            default: r_state <= S_DEC;
         endcase
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready       = w_in_ready;
   assign bus.out_valid      = r_out_valid;
   assign bus.out_reg_write  = r_ctrl.reg_write;
   assign bus.out_mem_write  = r_ctrl.mem_write;
   assign bus.out_mem_read   = r_ctrl.mem_read;
   assign bus.out_alu_src    = r_ctrl.alu_src;
   assign bus.out_mem_to_reg = r_ctrl.mem_to_reg;
   assign bus.out_alu_ctrl   = r_ctrl.alu_ctrl;
   assign bus.out_rdata1     = r_rdata1;
   assign bus.out_rdata2     = r_rdata2;
   assign bus.out_imm        = r_imm;
   assign bus.out_rdst       = r_rdst;
   assign bus.out_illegal    = r_illegal;

endmodule
